// File: rtl/vpu_issue_ctrl_if.sv
// Instruction-memory read port and execute-stage issue handshake for vpu_issue_ctrl.
interface vpu_issue_ctrl_if #(
    parameter int unsigned PC_W = 8,
    parameter int unsigned IW   = 32
);
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [IW-1:0]   imem_rdata;
    logic [IW-1:0]   ir;
    logic            ir_valid;
    logic            ex_ready;

    // Sequencer side: drives the memory request and the instruction register.
    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        output ir,
        output ir_valid,
        input  ex_ready
    );

    // Memory / execute side.
    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        input  ir,
        input  ir_valid,
        output ex_ready
    );
endinterface

// File: rtl/vpu_issue_ctrl.sv
// Fetch/issue sequencer: reads prog_len words from instruction memory starting at
// prog_base, drops illegal opcodes and hands legal ones to execute over valid/ready.
module vpu_issue_ctrl #(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned IW     = 32,
    parameter logic [4:0]  MAX_OP = 5'b01011
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PC_W-1:0]      prog_base,
    input  logic [PC_W-1:0]      prog_len,
    vpu_issue_ctrl_if.master     bus,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal,
    output logic [PC_W-1:0]      issued_cnt
);

    localparam int unsigned OP_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_FIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] remaining;
    logic [IW-1:0]   ir_q;
    logic            ir_valid_q;
    logic            imem_en_q;
    logic [OP_W-1:0] opcode;
    logic            op_illegal;
    logic            last_insn;

    assign opcode     = bus.imem_rdata[IW-1 -: OP_W];
    assign op_illegal = (opcode > MAX_OP);
    assign last_insn  = (remaining == '0);

    // Next-state selection; abort only matters in the three working states.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (prog_len == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (!op_illegal) begin
                    state_nxt = S_ISSUE;
                end else begin
                    state_nxt = last_insn ? S_FIN : S_FETCH;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (bus.ex_ready) begin
                    state_nxt = last_insn ? S_FIN : S_FETCH;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath registers and registered outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            remaining  <= '0;
            ir_q       <= '0;
            issued_cnt <= '0;
            imem_en_q  <= 1'b0;
            ir_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state      <= state_nxt;
            imem_en_q  <= (state_nxt == S_FETCH);
            ir_valid_q <= (state_nxt == S_ISSUE);
            busy       <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_FIN);
            illegal    <= (state == S_WAIT) && !abort && op_illegal;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc         <= prog_base;
                        remaining  <= prog_len;
                        issued_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (!abort) begin
                        pc        <= pc + PC_W'(1);
                        remaining <= remaining - PC_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!abort && !op_illegal) begin
                        ir_q <= bus.imem_rdata;
                    end
                end
                S_ISSUE: begin
                    // A handshake coinciding with abort still counts.
                    if (bus.ex_ready) begin
                        issued_cnt <= issued_cnt + PC_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // pc is the fetch address register, so it drives imem_addr directly.
    assign bus.imem_en   = imem_en_q;
    assign bus.imem_addr = pc;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = ir_valid_q;

endmodule
